// File: rtl/mest_pro_prog_loader_mem.sv
// MESTPro program memory: byte-serial loader plus same-cycle fetch port.
// The core only runs once a complete image is resident.
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 6
`endif

module mest_pro_prog_loader_mem #(
   parameter int INSTRUCTION_SIZE = `INSTRUCTION_SIZE,
   parameter int ADDR_BITS        = `ADDR_BITS
) (
   input  logic                        clk,
   input  logic                        i_reset,
   input  logic                        i_load_start,
   input  logic [ADDR_BITS-1:0]        i_load_words,
   input  logic                        i_byte_valid,
   input  logic [7:0]                  i_byte,
   output logic                        o_byte_ready,
   output logic                        o_load_done,
   output logic                        o_core_run,
   output logic [ADDR_BITS:0]          o_prog_len,
   input  logic                        i_req,
   input  logic [ADDR_BITS-1:0]        i_prog_counter,
   output logic [INSTRUCTION_SIZE-1:0] o_instruction,
   output logic                        o_req_err
);

   localparam int IS    = INSTRUCTION_SIZE;
   localparam int AB    = ADDR_BITS;
   localparam int DEPTH = 1 << AB;
   localparam int BPW   = IS / 8;
   localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOAD,
      ST_READY
   } state_t;

   state_t            state_q;
   logic [IS-1:0]     mem_q [DEPTH];
   logic [AB:0]       words_q;
   logic [AB-1:0]     wptr_q;
   logic [BCW-1:0]    bcnt_q;
   logic [IS-1:0]     asm_q;
   logic [AB:0]       plen_q;
   logic              done_q;
   logic              err_q;

   logic              beat;
   logic              last_byte;
   logic [IS-1:0]     asm_d;
   logic [AB:0]       plen_inc;
   logic [AB:0]       words_d;
   logic              pc_ok;

   assign beat      = (state_q == ST_LOAD) && i_byte_valid;
   assign last_byte = (bcnt_q == BCW'(BPW - 1));
   assign asm_d     = (asm_q << 8) | IS'(i_byte);
   assign plen_inc  = plen_q + {{AB{1'b0}}, 1'b1};
   assign pc_ok     = {1'b0, i_prog_counter} < plen_q;

   // A zero word count selects the full array depth.
   assign words_d = (i_load_words == '0) ? {1'b1, {AB{1'b0}}}
                                         : {1'b0, i_load_words};

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= ST_EMPTY;
         words_q <= '0;
         wptr_q  <= '0;
         bcnt_q  <= '0;
         asm_q   <= '0;
         plen_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= i_req && ((state_q != ST_READY) || !pc_ok);
         case (state_q)
            ST_EMPTY, ST_READY: begin
               if (i_load_start) begin
                  state_q <= ST_LOAD;
                  words_q <= words_d;
                  wptr_q  <= '0;
                  bcnt_q  <= '0;
                  asm_q   <= '0;
                  plen_q  <= '0;
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  asm_q <= asm_d;
                  if (last_byte) begin
                     mem_q[wptr_q] <= asm_d;
                     wptr_q        <= wptr_q + 1'b1;
                     bcnt_q        <= '0;
                     plen_q        <= plen_inc;
                     if (plen_inc == words_q) begin
                        state_q <= ST_READY;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign o_byte_ready  = (state_q == ST_LOAD);
   assign o_core_run    = (state_q == ST_READY);
   assign o_load_done   = done_q;
   assign o_prog_len    = plen_q;
   assign o_req_err     = err_q;
   assign o_instruction = ((state_q == ST_READY) && pc_ok)
                          ? mem_q[i_prog_counter] : '0;

endmodule
